// File: rtl/regfile_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp_if                                                |
// | Description : Bus bundle for the multi-port register file: read ports,     |
// |               two write ports, scoreboard set port and busy outputs.       |
// |               master - datapath side (drives addresses, writes, sets)      |
// |               slave  - register file side                                  |
// |   regfile_raddr [NUM_RD*ADDR_W] read addresses, port k at [k*ADDR_W+:]     |
// |   regfile_rdata [NUM_RD*DATA_W] read data, port k at [k*DATA_W+:]          |
// |   regfile_rbusy [NUM_RD]        scoreboard busy bit per read address       |
// |   wr0_en/addr/data, wr1_en/addr/data  write ports (wr1 wins a collision)   |
// |   sb_set_en/sb_set_addr          mark a destination register pending       |
// |   any_busy                       OR of all scoreboard bits                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] regfile_raddr;
  logic [NUM_RD*DATA_W-1:0] regfile_rdata;
  logic [NUM_RD-1:0]        regfile_rbusy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     any_busy;

  modport master (
    output regfile_raddr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr,
    input  regfile_rdata, regfile_rbusy, any_busy
  );

  modport slave (
    input  regfile_raddr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr,
    output regfile_rdata, regfile_rbusy, any_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : Parametrised register file with NUM_RD combinational read    |
// |               ports, two write ports (WB0 ALU, WB1 load/late) and a        |
// |               per-register scoreboard of pending writes for RAW stalls.    |
// |   clk  - rising-edge clock                                                 |
// |   rst  - synchronous active-high reset (clears data and busy bits)         |
// |   bus  - regfile_mp_if.slave: read ports, write ports, sb set, any_busy    |
// | Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding |
// |           of data (busy bits are never forwarded).                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  regfile_mp_if.slave  bus
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_depth];
  logic [c_depth-1:0] r_busy;
  logic [c_depth-1:0] w_busy_nxt;
  logic               w_wr0_ok;
  logic               w_wr1_ok;

  // Writes to the hard-wired zero register are simply dropped.
  assign w_wr0_ok = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
  assign w_wr1_ok = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));

  // Scoreboard next state: a write completion clears, an issue sets, and the
  // set is applied last so a new producer supersedes a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < c_depth; r++) begin
      if (bus.wr0_en && (bus.wr0_addr == ADDR_W'(r))) w_busy_nxt[r] = 1'b0;
      if (bus.wr1_en && (bus.wr1_addr == ADDR_W'(r))) w_busy_nxt[r] = 1'b0;
      if (bus.sb_set_en && (bus.sb_set_addr == ADDR_W'(r))) w_busy_nxt[r] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < c_depth; r++) r_mem[r] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr0_ok) r_mem[bus.wr0_addr] <= bus.wr0_data;
      // Issued second so wr1 wins a same-address collision.
      if (w_wr1_ok) r_mem[bus.wr1_addr] <= bus.wr1_data;
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.any_busy = |r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign w_raddr = bus.regfile_raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_rdata = r_mem[w_raddr];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr0_en && (bus.wr0_addr == w_raddr)) w_rdata = bus.wr0_data;
      if (bus.wr1_en && (bus.wr1_addr == w_raddr)) w_rdata = bus.wr1_data;
`endif
      if ((ZERO_REG != 0) && (w_raddr == '0)) w_rdata = '0;
    end

    assign bus.regfile_rdata[k*DATA_W +: DATA_W] = w_rdata;
    // Busy reflects registered state only, never same-cycle traffic.
    assign bus.regfile_rbusy[k] = r_busy[w_raddr];
  end : g_rd

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_mp                                                |
// | Description : Directed, table-driven bench for regfile_mp (2 read ports,   |
// |               32x32) plus hand sequences for bypass and mid-run reset.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rst;
    bit          w0e;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    bit          w1e;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    bit          sbe;
    logic [4:0]  sba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    bit          chk;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    bit          ea;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                     input bit w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                     input bit sbe, input logic [4:0] sba,
                     input logic [4:0] ra0, input logic [4:0] ra1,
                     input bit chk, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [1:0] eb, input bit ea);
    vec_t v;
    v.rst = r; v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d; v.sbe = sbe; v.sba = sba;
    v.ra0 = ra0; v.ra1 = ra1; v.chk = chk; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input bit w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input bit sbe, input logic [4:0] sba,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r;
    bus.wr0_en = w0e; bus.wr0_addr = w0a; bus.wr0_data = w0d;
    bus.wr1_en = w1e; bus.wr1_addr = w1a; bus.wr1_data = w1d;
    bus.sb_set_en = sbe; bus.sb_set_addr = sba;
    bus.regfile_raddr = {ra1, ra0};
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [1:0] eb, input bit ea);
    check({tag, " rdata0"}, bus.regfile_rdata[31:0], e0);
    check({tag, " rdata1"}, bus.regfile_rdata[63:32], e1);
    check({tag, " rbusy"}, {30'd0, bus.regfile_rbusy}, {30'd0, eb});
    check({tag, " any_busy"}, {31'd0, bus.any_busy}, {31'd0, ea});
  endtask

  logic [31:0] exp_byp;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //  rst w0e w0a  w0d           w1e w1a w1d           sbe sba ra0 ra1 chk e0            e1            eb     ea
    add(1, 1, 5, 32'hDEADBEEF,    0, 0, 0,             0, 0,  5,  1,  0,  0,            0,            2'b00, 0);
    add(1, 1, 5, 32'hDEADBEEF,    0, 0, 0,             0, 0,  5,  1,  0,  0,            0,            2'b00, 0);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  5,  3,  1,  0,            0,            2'b00, 0);
    add(0, 1, 3, 32'h12345678,    0, 0, 0,             0, 0,  5,  6,  1,  0,            0,            2'b00, 0);
    add(0, 1, 0, 32'hFFFFFFFF,    0, 0, 0,             0, 0,  3,  3,  1,  32'h12345678, 32'h12345678, 2'b00, 0);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  0,  3,  1,  0,            32'h12345678, 2'b00, 0);
    add(0, 1, 7, 32'hAAAA0000,    1, 7, 32'h0000BBBB,  0, 0,  3,  0,  1,  32'h12345678, 0,            2'b00, 0);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  7,  7,  1,  32'h0000BBBB, 32'h0000BBBB, 2'b00, 0);
    add(0, 0, 0, 0,               0, 0, 0,             1, 9,  9,  7,  1,  0,            32'h0000BBBB, 2'b00, 0);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  9,  8,  1,  0,            0,            2'b01, 1);
    add(0, 0, 0, 0,               1, 9, 32'hCAFEF00D,  0, 0,  8,  7,  1,  0,            32'h0000BBBB, 2'b00, 1);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  9,  9,  1,  32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 0);
    add(0, 1, 9, 32'h11111111,    0, 0, 0,             1, 9,  7,  8,  1,  32'h0000BBBB, 0,            2'b00, 0);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  9,  9,  1,  32'h11111111, 32'h11111111, 2'b11, 1);
    add(0, 0, 0, 0,               0, 0, 0,             1, 0,  0,  9,  1,  0,            32'h11111111, 2'b10, 1);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  0,  0,  1,  0,            0,            2'b00, 1);
    add(0, 0, 0, 0,               1, 9, 32'h22222222,  1, 2,  2,  0,  1,  0,            0,            2'b00, 1);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  2,  9,  1,  0,            32'h22222222, 2'b01, 1);
    add(0, 1, 2, 32'h00000033,    0, 0, 0,             0, 0,  1,  1,  1,  0,            0,            2'b00, 1);
    add(0, 0, 0, 0,               0, 0, 0,             0, 0,  2,  2,  1,  32'h00000033, 32'h00000033, 2'b00, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].w0e, vq[i].w0a, vq[i].w0d, vq[i].w1e, vq[i].w1a, vq[i].w1d,
            vq[i].sbe, vq[i].sba, vq[i].ra0, vq[i].ra1);
      #1;
      if (vq[i].chk) check_outs($sformatf("vec%0d", i), vq[i].e0, vq[i].e1, vq[i].eb, vq[i].ea);
    end

    // Same-cycle write and read of reg 4 (previously 0).
    @(negedge clk);
    drive(0, 1, 4, 32'h55, 0, 0, 0, 0, 0, 4, 4);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'h0;
`endif
    check_outs("byp_same", exp_byp, exp_byp, 2'b00, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4);
    #1;
    check_outs("byp_next", 32'h55, 32'h55, 2'b00, 0);

    // Double match: wr1 forwards over wr0; address 0 stays 0 even when written.
    @(negedge clk);
    drive(0, 1, 4, 32'h66, 1, 4, 32'h77, 0, 0, 4, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h77;
`else
    exp_byp = 32'h55;
`endif
    check_outs("byp_dbl", exp_byp, 0, 2'b00, 0);
    @(negedge clk);
    drive(0, 1, 0, 32'h99, 0, 0, 0, 0, 0, 4, 0);
    #1;
    check_outs("byp_zero", 32'h77, 0, 2'b00, 0);

    // Reset in the same cycle as a set and a write: both are dropped.
    @(negedge clk);
    drive(1, 1, 6, 32'hABC, 0, 0, 0, 1, 2, 2, 6);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6);
    #1;
    check_outs("rst_mid", 0, 0, 2'b00, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3);
    #1;
    check_outs("rst_mid2", 0, 0, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath. Successor to the 32x32, 2-read/1-write register file.
- Width, depth and read-port count are configurable.
- Two write ports: WB0 for ALU results, WB1 for load/late results.
- Per-register scoreboard of pending writes; the decode stage uses it to detect RAW hazards and stall.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and never goes busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- regfile_raddr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- regfile_rdata  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
- regfile_rbusy  out  NUM_RD  scoreboard busy bit for each read address.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- sb_set_en  in  1  mark one register pending (instruction issued).
- sb_set_addr  in  ADDR_W  destination register being marked.
- any_busy  out  1  OR of all scoreboard bits.

Behaviour:
- Storage is a 2**ADDR_W x DATA_W array plus a 2**ADDR_W-bit busy vector, both updated on posedge clk.
- Reset: when rst=1 at posedge clk, all registers and all busy bits clear to 0. Reset overrides every write and set in that cycle.
  - After reset: all regfile_rdata = 0, regfile_rbusy = 0, any_busy = 0.
  - If rst asserts mid-operation, any pending writes or sets in that cycle are dropped.
- Reads are combinational, with zero latency from regfile_raddr to regfile_rdata and regfile_rbusy.
- Writes are captured at posedge when the port's enable is high. Data is visible on reads in the next cycle (or the same cycle with bypass, see Optional Feature).
- Write collision: wr0 and wr1 to the same address in one cycle → wr1 wins.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - sb_set on address 0 is ignored and busy[0] stays 0.
- Scoreboard update per register r, in priority order:
  - rst → busy[r] = 0.
  - Else if sb_set_en and sb_set_addr==r → busy[r] = 1. A set beats a same-cycle clear: the new producer supersedes the old one.
  - Else if (wr0_en and wr0_addr==r) or (wr1_en and wr1_addr==r) → busy[r] = 0.
  - Else busy[r] holds.
- A write to a register that is not busy is legal: data updates and busy stays 0.
- Setting an already-busy register is legal: it stays busy until the next write.
- regfile_rbusy[k] = busy[raddr_k], computed combinationally from registered state only. It ignores same-cycle writes even when bypass is enabled.
- any_busy = |busy, combinational from registered state.
- Out-of-range addresses cannot occur, because depth is a full power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If a read address matches an enabled write address in the same cycle, regfile_rdata returns the write data (wr1 over wr0 on a double match).
  - ZERO_REG still forces 0 for address 0.
  - regfile_rbusy is unaffected.
- Undefined: reads return only array contents; a same-cycle write is visible from the next cycle.

Test Plan:
1. Reset/read-zero: run several cycles with rst=1 while wr0 writes addr 5 = 0xDEADBEEF, then deassert rst → rdata for addr 5 = 0, any_busy = 0.
2. Basic write/read on all ports: wr0 writes addr 3 = 0x12345678; next cycle raddr0=3, raddr1=3 → both ports read 0x12345678. Write addr 0 = 0xFFFFFFFF → addr 0 reads 0.
3. Write collision: wr0 writes addr 7 = 0xAAAA0000 and wr1 writes addr 7 = 0x0000BBBB in the same cycle → addr 7 reads 0x0000BBBB.
4. Scoreboard: sb_set addr 9 → next cycle rbusy=1 and any_busy=1. wr1 writes addr 9 → next cycle rbusy=0 and data updated. In one cycle, sb_set addr 9 plus wr0 writes addr 9 → busy stays 1. sb_set addr 0 → busy stays 0.
5. Bypass: wr0 writes addr 4 = 0x55 with raddr0=4 in the same cycle.
   - With REGFILE_BYPASS_EN: rdata0 = 0x55 in that cycle.
   - Without it: rdata0 = old value, then 0x55 in the next cycle.
6. Reset mid-operation: sb_set addr 2 and rst=1 in the same cycle → busy[2]=0 and any_busy=0 in the next cycle.
